// File: rtl/phy_tx_pkg.sv
// Shared definitions for the phy_tx slot scheduler: FSM encoding, idle fill word
// and requester ids.
package phy_tx_pkg;

  typedef enum logic {
    ST_TRAIN  = 1'b0,
    ST_ACTIVE = 1'b1
  } phy_state_e;

  localparam logic [31:0] IDLE_WORD_DEF = 32'hBCBC_BCBC;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/phy_tx_rr_arb2.sv
// Two-way round-robin pick. The grant is combinational; the pointer advances only
// when en_i is high and a grant is actually made.
module phy_tx_rr_arb2
  import phy_tx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_vld_o,
  output logic       gnt_id_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= REQ_0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    gnt_id_o = REQ_0;
    if (req_i == 2'b11) gnt_id_o = rr_ptr_q;
    else if (req_i[1])  gnt_id_o = REQ_1;
    gnt_vld_o = en_i & (|req_i);
  end

  // After any grant the other requester gets priority; idle slots leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld_o) rr_ptr_d = ~gnt_id_o;
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Slot scheduler in front of phy_tx: training idle slots, then round-robin word grants.
// Optional statistics counters are built when PHY_TX_SCHED_STATS_EN is defined.
module phy_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int          SLOT_LEN    = 32,
  parameter logic [31:0] IDLE_WORD   = IDLE_WORD_DEF,
  parameter int          TRAIN_SLOTS = 4
`ifdef PHY_TX_SCHED_STATS_EN
  ,
  parameter int          CNT_W       = 16
`endif
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in_0,
  input  logic        valid_in_0,
  output logic        ready_0,
  input  logic [31:0] data_in_1,
  input  logic        valid_in_1,
  output logic        ready_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        grant_id,
  output logic        slot_end,
  output logic        active,
  output phy_state_e  dbg_state
`ifdef PHY_TX_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] words_0,
  output logic [CNT_W-1:0] words_1,
  output logic [CNT_W-1:0] idle_slots
`endif
);

  localparam int SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int TW = $clog2(TRAIN_SLOTS + 1);

  phy_state_e      state_q, state_d;
  logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [TW-1:0]   train_cnt_q, train_cnt_d;
  logic [31:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            grant_q, grant_d;
  logic            train_tick;
  logic            train_last;
  logic            gnt_vld;
  logic            gnt_id;

  assign slot_end   = (slot_cnt_q == SW'(SLOT_LEN - 1));
  assign train_last = (train_cnt_q == TW'(TRAIN_SLOTS - 1));

  // FSM: state register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) state_q <= ST_TRAIN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == ST_TRAIN && slot_end && train_last) state_d = ST_ACTIVE;
  end

  // FSM: outputs
  always_comb begin
    active     = (state_q == ST_ACTIVE);
    train_tick = (state_q == ST_TRAIN) & slot_end;
    dbg_state  = state_q;
  end

  always_comb begin
    slot_cnt_d  = slot_end ? '0 : slot_cnt_q + SW'(1);
    train_cnt_d = train_tick ? train_cnt_q + TW'(1) : train_cnt_q;
  end

  phy_tx_rr_arb2 u_arb (
    .clk_i     (clk_32f),
    .rst_i     (reset),
    .en_i      (slot_end & active),
    .req_i     ({valid_in_1, valid_in_0}),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  // Handshake: a word transfers on valid_in_x & ready_x; ready_x is high only on
  // the slot_end cycle of an ACTIVE slot and only for the granted requester.
  assign ready_0 = gnt_vld & (gnt_id == REQ_0);
  assign ready_1 = gnt_vld & (gnt_id == REQ_1);

  // The output word is loaded at slot boundaries only, so it is held a full slot.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    if (slot_end) begin
      data_d  = IDLE_WORD;
      valid_d = 1'b0;
      if (gnt_vld) begin
        data_d  = (gnt_id == REQ_1) ? data_in_1 : data_in_0;
        valid_d = 1'b1;
        grant_d = gnt_id;
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      slot_cnt_q  <= '0;
      train_cnt_q <= '0;
      data_q      <= IDLE_WORD;
      valid_q     <= 1'b0;
      grant_q     <= REQ_0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      train_cnt_q <= train_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      grant_q     <= grant_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_id  = grant_q;

`ifdef PHY_TX_SCHED_STATS_EN
  logic [CNT_W-1:0] words_0_q, words_0_d;
  logic [CNT_W-1:0] words_1_q, words_1_d;
  logic [CNT_W-1:0] idle_q, idle_d;

  // All counters saturate at all-ones.
  always_comb begin
    words_0_d = words_0_q;
    words_1_d = words_1_q;
    idle_d    = idle_q;
    if (valid_in_0 && ready_0 && words_0_q != '1) words_0_d = words_0_q + CNT_W'(1);
    if (valid_in_1 && ready_1 && words_1_q != '1) words_1_d = words_1_q + CNT_W'(1);
    if (slot_end && active && !valid_q && idle_q != '1) idle_d = idle_q + CNT_W'(1);
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      words_0_q <= '0;
      words_1_q <= '0;
      idle_q    <= '0;
    end else begin
      words_0_q <= words_0_d;
      words_1_q <= words_1_d;
      idle_q    <= idle_d;
    end
  end

  assign words_0    = words_0_q;
  assign words_1    = words_1_q;
  assign idle_slots = idle_q;
`endif

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched: a checkpoint table over one long run plus
// hand-written sequences for training, alternation and reset mid-slot.
module tb_phy_tx_sched;
  import phy_tx_pkg::*;

  localparam logic [31:0] IW = 32'hBCBC_BCBC;
  localparam logic [31:0] WA = 32'h1234_5678;
  localparam logic [31:0] W0 = 32'hA0A0_A0A0;
  localparam logic [31:0] W1 = 32'hB1B1_B1B1;
  localparam logic [31:0] WC = 32'hC3C3_C3C3;
  localparam logic [31:0] WD = 32'hD4D4_D4D4;
  localparam logic [31:0] WE = 32'hE5E5_E5E5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d0 = '0, d1 = '0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        rdy0, rdy1, vout, gid, send, act;
  logic [31:0] dout;
  phy_state_e  dbg_state;
`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] words_0, words_1, idle_slots;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  phy_tx_sched dut (
    .clk_32f    (clk),
    .reset      (rst),
    .data_in_0  (d0),
    .valid_in_0 (v0),
    .ready_0    (rdy0),
    .data_in_1  (d1),
    .valid_in_1 (v1),
    .ready_1    (rdy1),
    .data_out   (dout),
    .valid_out  (vout),
    .grant_id   (gid),
    .slot_end   (send),
    .active     (act),
    .dbg_state  (dbg_state)
`ifdef PHY_TX_SCHED_STATS_EN
    ,
    .words_0    (words_0),
    .words_1    (words_1),
    .idle_slots (idle_slots)
`endif
  );

  typedef struct {
    int          cyc;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        e_r0, e_r1, e_vo;
    logic [31:0] e_do;
    logic        e_gid, e_act, e_se;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int c, logic a0, logic [31:0] b0, logic a1, logic [31:0] b1,
                              logic r0, logic r1, logic vo, logic [31:0] dd,
                              logic g, logic ac, logic se);
    vec_t v;
    v.cyc = c; v.v0 = a0; v.d0 = b0; v.v1 = a1; v.d1 = b1;
    v.e_r0 = r0; v.e_r1 = r1; v.e_vo = vo; v.e_do = dd;
    v.e_gid = g; v.e_act = ac; v.e_se = se;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expv);
    n_tests++;
    if (actual !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, actual, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur = 0;
  endtask

  task automatic run_to(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
  endtask

  initial begin
    int bad;
    int rcnt;
    logic [31:0] e;

    // Checkpoints over one run; inputs take effect from the row's cycle onward.
    vt.push_back(mk(  0, 1, WA, 0, '0, 0, 0, 0, IW, 0, 0, 0));
    vt.push_back(mk( 31, 1, WA, 0, '0, 0, 0, 0, IW, 0, 0, 1));
    vt.push_back(mk(127, 1, WA, 0, '0, 0, 0, 0, IW, 0, 0, 1));
    vt.push_back(mk(128, 1, WA, 0, '0, 0, 0, 0, IW, 0, 1, 0));
    vt.push_back(mk(159, 1, WA, 0, '0, 1, 0, 0, IW, 0, 1, 1));
    vt.push_back(mk(160, 1, WA, 0, '0, 0, 0, 1, WA, 0, 1, 0));
    vt.push_back(mk(170, 1, W0, 1, W1, 0, 0, 1, WA, 0, 1, 0));
    vt.push_back(mk(191, 1, W0, 1, W1, 0, 1, 1, WA, 0, 1, 1));
    vt.push_back(mk(192, 1, W0, 1, W1, 0, 0, 1, W1, 1, 1, 0));
    vt.push_back(mk(223, 1, W0, 1, W1, 1, 0, 1, W1, 1, 1, 1));
    vt.push_back(mk(224, 1, W0, 1, W1, 0, 0, 1, W0, 0, 1, 0));
    vt.push_back(mk(255, 1, W0, 1, W1, 0, 1, 1, W0, 0, 1, 1));
    vt.push_back(mk(256, 1, W0, 1, W1, 0, 0, 1, W1, 1, 1, 0));
    vt.push_back(mk(260, 0, W0, 0, W1, 0, 0, 1, W1, 1, 1, 0));
    vt.push_back(mk(287, 0, W0, 0, W1, 0, 0, 1, W1, 1, 1, 1));
    vt.push_back(mk(288, 0, W0, 0, W1, 0, 0, 0, IW, 1, 1, 0));
    vt.push_back(mk(290, 0, '0, 1, WC, 0, 0, 0, IW, 1, 1, 0));
    vt.push_back(mk(319, 0, '0, 1, WC, 0, 1, 0, IW, 1, 1, 1));
    vt.push_back(mk(320, 0, '0, 1, WC, 0, 0, 1, WC, 1, 1, 0));
    vt.push_back(mk(351, 0, '0, 1, WC, 0, 1, 1, WC, 1, 1, 1));
    vt.push_back(mk(383, 0, '0, 1, WC, 0, 1, 1, WC, 1, 1, 1));
    vt.push_back(mk(390, 1, WD, 1, WC, 0, 0, 1, WC, 1, 1, 0));
    vt.push_back(mk(415, 1, WD, 1, WC, 1, 0, 1, WC, 1, 1, 1));
    vt.push_back(mk(416, 1, WD, 1, WC, 0, 0, 1, WD, 0, 1, 0));
    vt.push_back(mk(447, 1, WD, 1, WC, 0, 1, 1, WD, 0, 1, 1));

    do_reset();
    foreach (vt[i]) begin
      run_to(vt[i].cyc);
      v0 = vt[i].v0; d0 = vt[i].d0; v1 = vt[i].v1; d1 = vt[i].d1;
      #1;
      chk($sformatf("c%0d_ready_0", vt[i].cyc),   32'(rdy0), 32'(vt[i].e_r0));
      chk($sformatf("c%0d_ready_1", vt[i].cyc),   32'(rdy1), 32'(vt[i].e_r1));
      chk($sformatf("c%0d_valid_out", vt[i].cyc), 32'(vout), 32'(vt[i].e_vo));
      chk($sformatf("c%0d_data_out", vt[i].cyc),  dout,      vt[i].e_do);
      chk($sformatf("c%0d_grant_id", vt[i].cyc),  32'(gid),  32'(vt[i].e_gid));
      chk($sformatf("c%0d_active", vt[i].cyc),    32'(act),  32'(vt[i].e_act));
      chk($sformatf("c%0d_slot_end", vt[i].cyc),  32'(send), 32'(vt[i].e_se));
    end

    // Both requesters valid from reset: silent training, then strict alternation 0,1,0,1.
    v0 = 1'b1; d0 = W0; v1 = 1'b1; d1 = W1;
    do_reset();
    exp_q.push_back(W0); exp_q.push_back(W1);
    exp_q.push_back(W0); exp_q.push_back(W1);
    bad = 0;
    rcnt = 0;
    for (int c = 0; c < 287; c++) begin
      run_to(c);
      #1;
      if (c < 128 && (rdy0 || rdy1 || vout || dout !== IW || act)) bad++;
      if (c >= 128) begin
        if ((rdy0 || rdy1) && !send) bad++;
        if (rdy0 && rdy1) bad++;
        if (rdy0 || rdy1) rcnt++;
        if (c == 160 || c == 192 || c == 224 || c == 256) begin
          e = exp_q.pop_front();
          chk($sformatf("alt_word_c%0d", c), dout, e);
          chk($sformatf("alt_valid_c%0d", c), 32'(vout), 32'd1);
        end
      end
    end
    chk("alt_protocol_violations", bad, 0);
    chk("alt_ready_cycles", rcnt, 4);
    chk("alt_queue_drained", exp_q.size(), 0);

    // Reset at slot_cnt=10 of a data slot owned by requester 1.
    v0 = 1'b0; d0 = '0; v1 = 1'b1; d1 = WE;
    do_reset();
    run_to(170);
    #1;
    chk("pre_rst_grant_id", 32'(gid), 32'd1);
    chk("pre_rst_data_out", dout, WE);
    #1 rst = 1'b1;
    #1;
    chk("rst_data_out", dout, IW);
    chk("rst_valid_out", 32'(vout), 32'd0);
    chk("rst_grant_id", 32'(gid), 32'd0);
    chk("rst_active", 32'(act), 32'd0);
    chk("rst_ready_1", 32'(rdy1), 32'd0);
    chk("rst_slot_end", 32'(send), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_TRAIN));
    @(negedge clk);
    rst = 1'b0;
    cur = 0;
    bad = 0;
    for (int c = 0; c < 159; c++) begin
      run_to(c);
      #1;
      if (rdy0 || rdy1 || vout || dout !== IW) bad++;
      if (act !== (c >= 128)) bad++;
    end
    chk("retrain_quiet", bad, 0);
    run_to(159);
    #1;
    chk("retrain_ready_1", 32'(rdy1), 32'd1);
    run_to(160);
    #1;
    chk("retrain_data_out", dout, WE);
    chk("retrain_grant_id", 32'(gid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
